// File: rtl/mips_lsu_pkg.sv
// Shared types and helpers for the MIPS-1 load/store unit.
//   lsu_op_t    : the eight load/store opcodes (all encodings are defined)
//   lsu_state_t : LSU sequencer states
//   is_load / is_store : opcode class helpers
package mips_lsu_pkg;

    localparam int unsigned LSU_DMEM_DEPTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LBU = 3'd1,
        LH  = 3'd2,
        LHU = 3'd3,
        LW  = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2
    } lsu_state_t;

    function automatic logic is_load(input lsu_op_t op);
        logic res;
        case (op)
            LB, LBU, LH, LHU, LW: res = 1'b1;
            default:              res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_store(input lsu_op_t op);
        return !is_load(op);
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane steering for the load/store unit (little-endian).
// Ports:
//   rdata_i      : word read from memory (load source)
//   old_word_i   : previously read word (store merge base)
//   wdata_i      : right-aligned store data
//   addr_lo_i    : byte offset within the word
//   op_i         : load/store opcode
//   load_data_o  : extracted and extended load value
//   store_word_o : full word to write (merged for SB/SH, wdata for SW)
module lsu_byte_lane
    import mips_lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  addr_lo_i,
    input  lsu_op_t     op_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword of the read word
    always_comb begin
        byte_s = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_s = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    end

    // Load extension
    always_comb begin
        load_data_o = rdata_i;
        case (op_i)
            LB:      load_data_o = {{24{byte_s[7]}}, byte_s};
            LBU:     load_data_o = {24'h000000, byte_s};
            LH:      load_data_o = {{16{half_s[15]}}, half_s};
            LHU:     load_data_o = {16'h0000, half_s};
            LW:      load_data_o = rdata_i;
            default: load_data_o = rdata_i;
        endcase
    end

    // Store merge: replace only the targeted lane of the old word
    always_comb begin
        store_word_o = old_word_i;
        case (op_i)
            SB:      store_word_o[{addr_lo_i, 3'b000} +: 8]     = wdata_i[7:0];
            SH:      store_word_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            SW:      store_word_o = wdata_i;
            default: store_word_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of a word-addressed data memory.
// Converts byte-addressed requests into word accesses, performs
// read-modify-write for SB/SH and returns extended, registered load data.
// Ports:
//   clk_i, rst_n_i            : clock, async active-low reset
//   req_valid_i/req_ready_o   : request handshake (ready only in IDLE)
//   req_op_i, req_addr_i      : opcode and byte address
//   req_wdata_i, req_rd_i     : store data (right-aligned), load destination
//   rsp_valid_o/rdata/rd      : one-cycle load response
//   exc_o, exc_badaddr_o      : one-cycle address-error pulse and address
//   dmem_*                    : word-addressed memory interface
module mem_lsu
    import mips_lsu_pkg::*;
#(
    parameter int unsigned DMEM_DEPTH = LSU_DMEM_DEPTH_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic [4:0]  rsp_rd_o,
    output logic        exc_o,
    output logic [31:0] exc_badaddr_o,
    output logic        dmem_write_en_o,
    output logic [31:0] dmem_address_o,
    output logic [31:0] dmem_write_data_o,
    input  logic [31:0] dmem_read_data_i
);

    lsu_state_t  state_q, state_d;
    lsu_op_t     op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic [31:0] merge_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic [4:0]  rsp_rd_q;
    logic        exc_q;
    logic [31:0] badaddr_q;

    lsu_op_t     req_op_s;
    logic        addr_err_s;
    logic        accept_s;
    logic        wen_s;
    logic [31:0] load_data_s;
    logic [31:0] store_word_s;

    assign req_op_s = lsu_op_t'(req_op_i);

    // Address error: out-of-range word index or misaligned halfword/word
    always_comb begin
        addr_err_s = 1'b0;
        if ({2'b00, req_addr_i[31:2]} >= DMEM_DEPTH) begin
            addr_err_s = 1'b1;
        end else begin
            case (req_op_s)
                LH, LHU, SH: addr_err_s = req_addr_i[0];
                LW, SW:      addr_err_s = (req_addr_i[1:0] != 2'b00);
                default:     addr_err_s = 1'b0;
            endcase
        end
    end

    // Sequencer next state, acceptance and memory write strobe
    always_comb begin
        state_d  = state_q;
        accept_s = 1'b0;
        wen_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i && !addr_err_s) begin
                    accept_s = 1'b1;
                    state_d  = ACCESS;
                end else begin
                    state_d  = IDLE;
                end
            end
            ACCESS: begin
                if (op_q == SW) begin
                    wen_s = 1'b1;
                end else begin
                    wen_s = 1'b0;
                end
                if (op_q == SB || op_q == SH) begin
                    state_d = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                wen_s   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch; addr_q also keeps dmem_address_o stable between accesses
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_q    <= LB;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            rd_q    <= 5'd0;
        end else if (accept_s) begin
            op_q    <= req_op_s;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            rd_q    <= req_rd_i;
        end else begin
            op_q    <= op_q;
            addr_q  <= addr_q;
            wdata_q <= wdata_q;
            rd_q    <= rd_q;
        end
    end

    // Merge register: old memory word for partial-word stores
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            merge_q <= 32'h0000_0000;
        end else if (state_q == ACCESS && is_store(op_q)) begin
            merge_q <= dmem_read_data_i;
        end else begin
            merge_q <= merge_q;
        end
    end

    // Load response registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_rd_q    <= 5'd0;
        end else if (state_q == ACCESS && is_load(op_q)) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_data_s;
            rsp_rd_q    <= rd_q;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= rsp_rdata_q;
            rsp_rd_q    <= rsp_rd_q;
        end
    end

    // Address-error pulse; only raised from IDLE so it never coincides with a response
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            exc_q     <= 1'b0;
            badaddr_q <= 32'h0000_0000;
        end else if (state_q == IDLE && req_valid_i && addr_err_s) begin
            exc_q     <= 1'b1;
            badaddr_q <= req_addr_i;
        end else begin
            exc_q     <= 1'b0;
            badaddr_q <= badaddr_q;
        end
    end

    lsu_byte_lane u_lane (
        .rdata_i      (dmem_read_data_i),
        .old_word_i   (merge_q),
        .wdata_i      (wdata_q),
        .addr_lo_i    (addr_q[1:0]),
        .op_i         (op_q),
        .load_data_o  (load_data_s),
        .store_word_o (store_word_s)
    );

    assign req_ready_o       = (state_q == IDLE);
    assign rsp_valid_o       = rsp_valid_q;
    assign rsp_rdata_o       = rsp_rdata_q;
    assign rsp_rd_o          = rsp_rd_q;
    assign exc_o             = exc_q;
    assign exc_badaddr_o     = badaddr_q;
    assign dmem_write_en_o   = wen_s;
    assign dmem_address_o    = {2'b00, addr_q[31:2]};
    assign dmem_write_data_o = wen_s ? store_word_s : 32'h0000_0000;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: a 32-word data memory, a transaction-level reference
// model (per-cycle expectation tables) and directed plus random stimulus.
module tb_mem_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        exc;
    logic [31:0] exc_badaddr;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;

    mem_lsu #(.DMEM_DEPTH(32)) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_op_i          (req_op),
        .req_addr_i        (req_addr),
        .req_wdata_i       (req_wdata),
        .req_rd_i          (req_rd),
        .rsp_valid_o       (rsp_valid),
        .rsp_rdata_o       (rsp_rdata),
        .rsp_rd_o          (rsp_rd),
        .exc_o             (exc),
        .exc_badaddr_o     (exc_badaddr),
        .dmem_write_en_o   (dmem_we),
        .dmem_address_o    (dmem_addr),
        .dmem_write_data_o (dmem_wdata),
        .dmem_read_data_i  (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, synchronous write
    logic [31:0] mem [32];
    assign dmem_rdata = (dmem_addr < 32'd32) ? mem[dmem_addr[4:0]] : 32'h0;
    always @(posedge clk) begin
        if (dmem_we && dmem_addr < 32'd32) mem[dmem_addr[4:0]] <= dmem_wdata;
    end

    // Reference model state
    logic [31:0] ref_mem [32];
    int          cyc;
    int          busy_until;
    logic [29:0] cur_waddr;
    logic [31:0] exp_rsp_data [int];
    logic [4:0]  exp_rsp_rd   [int];
    logic [31:0] exp_exc_addr [int];
    logic [31:0] exp_w_data   [int];
    int          exp_w_idx    [int];

    int n_chk;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        exp_rsp_data.delete();
        exp_rsp_rd.delete();
        exp_exc_addr.delete();
        exp_w_data.delete();
        exp_w_idx.delete();
        busy_until = cyc;
        cur_waddr  = 30'd0;
    endtask

    // Compare every DUT output against the model for the current cycle
    task automatic check_cycle();
        logic rv, ev, wv;
        rv = exp_rsp_data.exists(cyc);
        ev = exp_exc_addr.exists(cyc);
        wv = exp_w_data.exists(cyc);
        chk("req_ready", 32'(req_ready), 32'(cyc >= busy_until));
        chk("rsp_valid", 32'(rsp_valid), 32'(rv));
        if (rv) begin
            chk("rsp_rdata", rsp_rdata, exp_rsp_data[cyc]);
            chk("rsp_rd", 32'(rsp_rd), 32'(exp_rsp_rd[cyc]));
            exp_rsp_data.delete(cyc);
            exp_rsp_rd.delete(cyc);
        end
        chk("exc", 32'(exc), 32'(ev));
        if (ev) begin
            chk("exc_badaddr", exc_badaddr, exp_exc_addr[cyc]);
            exp_exc_addr.delete(cyc);
        end
        chk("dmem_we", 32'(dmem_we), 32'(wv));
        if (wv) begin
            chk("dmem_wdata", dmem_wdata, exp_w_data[cyc]);
            ref_mem[exp_w_idx[cyc]] = exp_w_data[cyc];
            exp_w_data.delete(cyc);
            exp_w_idx.delete(cyc);
        end
        chk("dmem_addr", dmem_addr, {2'b00, cur_waddr});
    endtask

    // Transaction-level effect of an accepted request
    task automatic model_accept(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] wd, input logic [4:0] rd);
        logic [29:0] w;
        logic [31:0] old, b, h, nw;
        int          k, idx;
        logic        err;
        w   = a[31:2];
        err = (w >= 30'd32)
           || ((op == 3'd2 || op == 3'd3 || op == 3'd6) && a[0])
           || ((op == 3'd4 || op == 3'd7) && a[1:0] != 2'b00);
        if (err) begin
            exp_exc_addr[cyc + 1] = a;
            return;
        end
        cur_waddr = w;
        idx = int'(w);
        old = ref_mem[idx];
        k   = int'(a[1:0]);
        b   = (old >> (8 * k)) & 32'hFF;
        h   = (old >> (8 * (k & 2))) & 32'hFFFF;
        if (op <= 3'd4) begin
            case (op)
                3'd0:    exp_rsp_data[cyc + 2] = (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
                3'd1:    exp_rsp_data[cyc + 2] = b;
                3'd2:    exp_rsp_data[cyc + 2] = (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
                3'd3:    exp_rsp_data[cyc + 2] = h;
                default: exp_rsp_data[cyc + 2] = old;
            endcase
            exp_rsp_rd[cyc + 2] = rd;
            busy_until = cyc + 2;
        end else if (op == 3'd7) begin
            exp_w_data[cyc + 1] = wd;
            exp_w_idx[cyc + 1]  = idx;
            busy_until = cyc + 2;
        end else begin
            if (op == 3'd5)
                nw = (old & ~(32'hFF << (8 * k))) | ((wd & 32'hFF) << (8 * k));
            else
                nw = (old & ~(32'hFFFF << (8 * (k & 2)))) | ((wd & 32'hFFFF) << (8 * (k & 2)));
            exp_w_data[cyc + 2] = nw;
            exp_w_idx[cyc + 2]  = idx;
            busy_until = cyc + 3;
        end
    endtask

    // One clock cycle: check outputs, then drive the next request
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd);
        @(negedge clk);
        check_cycle();
        req_valid = v;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        req_rd    = rd;
        if (v && cyc >= busy_until) model_accept(op, a, wd, rd);
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic run_load(input logic [2:0] op, input logic [31:0] a,
                            input logic [4:0] rd, input logic [31:0] lit, input string name);
        step(1'b1, op, a, 32'h0, rd);
        idle();
        idle();
        chk(name, rsp_rdata, lit);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_rd"}, 32'(rsp_rd), 32'd0);
        chk({tag, "_exc"}, 32'(exc), 32'd0);
        chk({tag, "_badaddr"}, exc_badaddr, 32'd0);
        chk({tag, "_we"}, 32'(dmem_we), 32'd0);
        chk({tag, "_addr"}, dmem_addr, 32'd0);
        chk({tag, "_wdata"}, dmem_wdata, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_op = 3'd0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        req_rd = 5'd0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();

        // 1. SW then LW
        step(1'b1, 3'd7, 32'h8, 32'hDEADBEEF, 5'd0);
        idle();
        chk("sw_we_lit", 32'(dmem_we), 32'd1);
        chk("sw_data_lit", dmem_wdata, 32'hDEADBEEF);
        chk("sw_addr_lit", dmem_addr, 32'd2);
        run_load(3'd4, 32'h8, 5'd3, 32'hDEADBEEF, "lw_lit");
        chk("lw_rd_lit", 32'(rsp_rd), 32'd3);

        // 2. sub-word loads
        run_load(3'd0, 32'hB, 5'd4, 32'hFFFFFFDE, "lb_lit");
        run_load(3'd1, 32'hB, 5'd5, 32'h000000DE, "lbu_lit");
        run_load(3'd2, 32'h8, 5'd6, 32'hFFFFBEEF, "lh_lit");
        run_load(3'd3, 32'hA, 5'd7, 32'h0000DEAD, "lhu_lit");

        // 3. SB read-modify-write
        step(1'b1, 3'd5, 32'h9, 32'h12, 5'd0);
        idle();
        chk("sb_ready_t1_lit", 32'(req_ready), 32'd0);
        idle();
        chk("sb_ready_t2_lit", 32'(req_ready), 32'd0);
        chk("sb_we_lit", 32'(dmem_we), 32'd1);
        chk("sb_data_lit", dmem_wdata, 32'hDEAD12EF);
        idle();

        // 4. address errors
        step(1'b1, 3'd4, 32'h6, 32'h0, 5'd1);
        idle();
        chk("lw_mis_exc_lit", exc_badaddr, 32'h6);
        step(1'b1, 3'd6, 32'h3, 32'h5555, 5'd1);
        idle();
        chk("sh_mis_exc_lit", exc_badaddr, 32'h3);
        chk("sh_mis_we_lit", 32'(dmem_we), 32'd0);
        step(1'b1, 3'd4, 32'h80, 32'h0, 5'd1);
        idle();
        chk("lw_oor_exc_lit", 32'(exc), 32'd1);
        idle();

        // 5. reset during the WRITE of an SH
        step(1'b1, 3'd7, 32'h10, 32'h11223344, 5'd0);
        idle();
        step(1'b1, 3'd6, 32'h12, 32'h0000ABCD, 5'd0);
        idle();
        @(posedge clk);
        #1;
        chk("sh_in_write", 32'(dmem_we), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_mem", mem[4], 32'h11223344);
        cyc += 2;
        model_clear();

        // 6. back-to-back loads with valid held high
        for (int i = 0; i < 16; i++) begin
            a = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
            step(1'b1, (i % 2 == 0) ? 3'd4 : 3'd1, a | 32'(i % 4 * (i % 2)), 32'h0, 5'(i + 8));
        end
        idle();
        idle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) a = $urandom;
            else a = {24'd0, 6'($urandom_range(0, 33)), 2'($urandom_range(0, 3))};
            step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), a, $urandom,
                 5'($urandom_range(0, 31)));
        end
        for (int i = 0; i < 4; i++) idle();

        for (int i = 0; i < 32; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
